// File: rtl/cpu_loader_pkg.sv
// Shared opcodes, FSM encoding and word geometry for the cpu_loader byte-stream front end.
// Pure declarations: no latency and no backpressure of their own.
package cpu_loader_pkg;

    localparam logic [7:0] CMD_LOAD_I = 8'h01;
    localparam logic [7:0] CMD_LOAD_D = 8'h02;
    localparam logic [7:0] CMD_RUN    = 8'h03;
    localparam logic [7:0] CMD_HALT   = 8'h04;

    localparam int IMEM_WORD_BYTES = 4;
    localparam int DMEM_WORD_BYTES = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_DATA,
        ST_WRITE,
        ST_RUN,
        ST_ERR
    } state_t;

endpackage

// File: rtl/cpu_loader_packer.sv
// Little-endian word assembler for 4- or 8-byte words; word_full_o flags the byte that completes a word.
// Bytes land in the cycle they are loaded; the caller owns backpressure by withholding load_i.
module cpu_loader_packer
    import cpu_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic        size8_i,
    input  logic [7:0]  byte_i,
    output logic [63:0] word_o,
    output logic        word_full_o
);

    logic [2:0]  cnt_q;
    logic [63:0] word_q;
    logic [2:0]  last_idx;

    assign last_idx    = size8_i ? 3'(DMEM_WORD_BYTES - 1) : 3'(IMEM_WORD_BYTES - 1);
    assign word_full_o = load_i && (cnt_q == last_idx);
    assign word_o      = word_q;

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            cnt_q  <= 3'd0;
            word_q <= 64'd0;
        end else if (load_i) begin
            word_q[{cnt_q, 3'b000} +: 8] <= byte_i;
            cnt_q                        <= cnt_q + 3'd1;
        end
    end

endmodule

// File: rtl/cpu_loader.sv
// Host byte-stream loader: fills cpu imem/dmem via external write ports and gates cpu enable.
// Write strobe follows the last byte of a word by one cycle; in_ready drops during writes and in ERR.
module cpu_loader
    import cpu_loader_pkg::*;
#(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        enable,
    output logic        busy,
    output logic        error,
    output logic [15:0] words_done
);

    state_t      state_q, state_d;
    logic [1:0]  hdr_idx_q, hdr_idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] base_q, base_d;
    logic        is_d_q, is_d_d;
    logic [15:0] words_done_q, words_done_d;
    logic [15:0] widx_q, widx_d;

    logic        accept;
    logic        pk_load;
    logic        pk_clear;
    logic        pk_full;
    logic [63:0] pk_word;
    logic [16:0] hdr_end;
    logic [16:0] depth;

    assign in_ready = (state_q != ST_WRITE) && (state_q != ST_ERR);
    assign accept   = in_valid && in_ready;

    // Range check uses 17 bits so base+cnt cannot wrap back into the legal window.
    assign hdr_end = {1'b0, in_data, base_q[7:0]} + {1'b0, cnt_q};
    assign depth   = is_d_q ? 17'(DMEM_WORDS) : 17'(IMEM_WORDS);

    always_comb begin
        state_d      = state_q;
        hdr_idx_d    = hdr_idx_q;
        cnt_d        = cnt_q;
        base_d       = base_q;
        is_d_d       = is_d_q;
        words_done_d = words_done_q;
        widx_d       = widx_q;
        pk_load      = 1'b0;
        pk_clear     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    case (in_data)
                        CMD_LOAD_I, CMD_LOAD_D: begin
                            state_d      = ST_HDR;
                            is_d_d       = (in_data == CMD_LOAD_D);
                            hdr_idx_d    = 2'd0;
                            words_done_d = 16'd0;
                            pk_clear     = 1'b1;
                        end
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_HALT: state_d = ST_IDLE;
                        default:  state_d = ST_ERR;
                    endcase
                end
            end
            ST_HDR: begin
                if (accept) begin
                    hdr_idx_d = hdr_idx_q + 2'd1;
                    case (hdr_idx_q)
                        2'd0: cnt_d[7:0]   = in_data;
                        2'd1: cnt_d[15:8]  = in_data;
                        2'd2: base_d[7:0]  = in_data;
                        default: begin
                            base_d[15:8] = in_data;
                            if (hdr_end > depth) begin
                                state_d = ST_ERR;
                            end else if (cnt_q == 16'd0) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d = ST_DATA;
                            end
                        end
                    endcase
                end
            end
            ST_DATA: begin
                if (accept) begin
                    pk_load = 1'b1;
                    if (pk_full) begin
                        state_d = ST_WRITE;
                        widx_d  = base_q + words_done_q;
                    end
                end
            end
            ST_WRITE: begin
                words_done_d = words_done_q + 16'd1;
                pk_clear     = 1'b1;
                state_d      = ((words_done_q + 16'd1) == cnt_q) ? ST_IDLE : ST_DATA;
            end
            ST_RUN: begin
                if (accept && (in_data == CMD_HALT)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_ERR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hdr_idx_q    <= 2'd0;
            cnt_q        <= 16'd0;
            base_q       <= 16'd0;
            is_d_q       <= 1'b0;
            words_done_q <= 16'd0;
            widx_q       <= 16'd0;
        end else begin
            state_q      <= state_d;
            hdr_idx_q    <= hdr_idx_d;
            cnt_q        <= cnt_d;
            base_q       <= base_d;
            is_d_q       <= is_d_d;
            words_done_q <= words_done_d;
            widx_q       <= widx_d;
        end
    end

    cpu_loader_packer u_packer (
        .clk         (clk),
        .rst         (rst),
        .load_i      (pk_load),
        .clear_i     (pk_clear),
        .size8_i     (is_d_q),
        .byte_i      (in_data),
        .word_o      (pk_word),
        .word_full_o (pk_full)
    );

    assign wen_ext     = (state_q == ST_WRITE) && !is_d_q;
    assign wen_ext_2   = (state_q == ST_WRITE) && is_d_q;
    assign addr_ext    = {46'd0, widx_q, 2'b00};
    assign addr_ext_2  = {45'd0, widx_q, 3'b000};
    assign wdata_ext   = pk_word[31:0];
    assign wdata_ext_2 = pk_word;
    assign enable      = (state_q == ST_RUN);
    assign busy        = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_WRITE);
    assign error       = (state_q == ST_ERR);
    assign words_done  = words_done_q;

endmodule

// File: tb/tb_cpu_loader.sv
// Directed/random bench for cpu_loader: frames are built from byte lists and expected writes are
// derived arithmetically from the frame contents, then matched against strobes seen on the ports.
module tb_cpu_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic [63:0] wdata_ext_2;
    logic        enable;
    logic        busy;
    logic        error;
    logic [15:0] words_done;

    always #5 clk = ~clk;

    cpu_loader #(.IMEM_WORDS(128), .DMEM_WORDS(128)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_data     (in_data),
        .in_ready    (in_ready),
        .addr_ext    (addr_ext),
        .wen_ext     (wen_ext),
        .wdata_ext   (wdata_ext),
        .addr_ext_2  (addr_ext_2),
        .wen_ext_2   (wen_ext_2),
        .wdata_ext_2 (wdata_ext_2),
        .enable      (enable),
        .busy        (busy),
        .error       (error),
        .words_done  (words_done)
    );

    typedef struct packed {
        logic        d;
        logic [63:0] addr;
        logic [63:0] data;
    } wr_t;

    int          checks = 0;
    int          errors = 0;
    int          viol   = 0;
    wr_t         exp_q[$];
    wr_t         act_q[$];
    logic [7:0]  pay[$];

    // Observe every strobe and flag illegal combinations.
    always @(negedge clk) begin
        if (wen_ext)   act_q.push_back({1'b0, addr_ext, 32'h0, wdata_ext});
        if (wen_ext_2) act_q.push_back({1'b1, addr_ext_2, wdata_ext_2});
        if ((wen_ext || wen_ext_2) && (in_ready || enable || (wen_ext && wen_ext_2))) viol++;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t;
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        while (!in_ready && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst      = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic rand_pay(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    // Sends a complete LOAD frame; payload only goes out when the frame is in range.
    task automatic do_load(input bit d, input int cnt, input int base, input bit gaps);
        int nb;
        logic [63:0] w;
        nb = d ? 8 : 4;
        send_byte(d ? 8'h02 : 8'h01, 0);
        send_byte(8'(cnt), 0);
        send_byte(8'(cnt >> 8), 0);
        send_byte(8'(base), 0);
        send_byte(8'(base >> 8), 0);
        if (base + cnt <= 128) begin
            for (int k = 0; k < cnt; k++) begin
                w = 64'd0;
                for (int i = 0; i < nb; i++) w |= 64'(pay[k*nb + i]) << (8*i);
                exp_q.push_back({d, 64'((base + k) * nb), w});
            end
            for (int i = 0; i < cnt * nb; i++) send_byte(pay[i], gaps ? int'($urandom_range(0, 3)) : 0);
        end
    endtask

    task automatic compare_writes(input string tag);
        int n;
        repeat (3) @(negedge clk);
        chk({tag, "_count"}, 64'(act_q.size()), 64'(exp_q.size()));
        n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_port"}, 64'(act_q[i].d), 64'(exp_q[i].d));
            chk({tag, "_addr"}, act_q[i].addr, exp_q[i].addr);
            chk({tag, "_data"}, act_q[i].data, exp_q[i].data);
        end
        act_q.delete();
        exp_q.delete();
    endtask

    initial begin
        int b;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_in_ready",   64'(in_ready),   64'd1);
        chk("rst_enable",     64'(enable),     64'd0);
        chk("rst_busy",       64'(busy),       64'd0);
        chk("rst_error",      64'(error),      64'd0);
        chk("rst_words_done", 64'(words_done), 64'd0);
        chk("rst_wen",        64'({wen_ext, wen_ext_2}), 64'd0);
        chk("rst_addr",       addr_ext | addr_ext_2, 64'd0);
        chk("rst_wdata",      wdata_ext_2, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        pay = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        do_load(1'b0, 2, 3, 1'b0);
        compare_writes("load_i_fixed");
        chk("load_i_words_done", 64'(words_done), 64'd2);
        chk("load_i_busy_after", 64'(busy), 64'd0);

        pay = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        do_load(1'b1, 1, 0, 1'b0);
        compare_writes("load_d_fixed");
        chk("load_d_words_done", 64'(words_done), 64'd1);

        chk("run_enable_before", 64'(enable), 64'd0);
        send_byte(8'h03, 0);
        chk("run_enable_on", 64'(enable), 64'd1);
        chk("run_busy", 64'(busy), 64'd0);
        send_byte(8'h01, 1);
        send_byte(8'h55, 0);
        chk("run_enable_held", 64'(enable), 64'd1);
        chk("run_error", 64'(error), 64'd0);
        send_byte(8'h04, 0);
        chk("halt_enable_off", 64'(enable), 64'd0);
        compare_writes("run_no_write");

        b = int'($urandom_range(0, 124));
        rand_pay(16);
        do_load(1'b0, 4, b, 1'b0);
        compare_writes("load_i_rand_nogap");
        do_load(1'b0, 4, b, 1'b1);
        compare_writes("load_i_rand_gap");
        chk("load_i_rand_words_done", 64'(words_done), 64'd4);

        rand_pay(24);
        do_load(1'b1, 3, int'($urandom_range(0, 125)), 1'b1);
        compare_writes("load_d_rand");

        rand_pay(4);
        do_load(1'b0, 1, 127, 1'b1);
        compare_writes("load_i_top_word");

        rand_pay(16);
        send_byte(8'h02, 0);
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        for (int i = 0; i < 5; i++) send_byte(pay[i], 0);
        chk("mid_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_wdata", wdata_ext_2, 64'd0);
        chk("mid_rst_words_done", 64'(words_done), 64'd0);
        rst = 1'b0;
        compare_writes("mid_rst_no_write");
        do_load(1'b1, 1, 5, 1'b0);
        compare_writes("after_rst_load_d");

        do_load(1'b0, 2, 127, 1'b0);
        repeat (2) @(negedge clk);
        chk("range_error", 64'(error), 64'd1);
        chk("range_in_ready", 64'(in_ready), 64'd0);
        chk("range_busy", 64'(busy), 64'd0);
        compare_writes("range_no_write");
        do_reset();
        chk("range_rst_error", 64'(error), 64'd0);

        send_byte(8'h07, 0);
        chk("badcmd_error", 64'(error), 64'd1);
        chk("badcmd_in_ready", 64'(in_ready), 64'd0);
        chk("badcmd_enable", 64'(enable), 64'd0);
        do_reset();
        chk("badcmd_rst_ready", 64'(in_ready), 64'd1);

        chk("strobe_rules", 64'(viol), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
